// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage: PC register, instruction-memory
//               request handshake, and fetch->decode pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall_fetch,
    input  logic               i_stall_dec,
    input  logic               i_flush_dec,
    input  logic               i_pc_src_exec,
    input  logic [ADDR_W-1:0]  i_pc_target_exec,
    input  logic               i_stall_d,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic               o_stall_i,
    output logic [INSTR_W-1:0] o_instr_dec,
    output logic [ADDR_W-1:0]  o_pc_dec,
    output logic [ADDR_W-1:0]  o_pc_plus4_dec,
    output logic               o_valid_dec
);

    localparam logic [INSTR_W-1:0] c_nop  = INSTR_W'(32'h0000_0013);
    localparam logic [ADDR_W-1:0]  c_four = ADDR_W'(4);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_pend_v;
    logic [ADDR_W-1:0]   r_pend_pc;
    logic [INSTR_W-1:0]  r_buf_instr;

    logic                w_redir;
    logic                w_redir_any;
    logic [ADDR_W-1:0]   w_target;
    logic [ADDR_W-1:0]   w_pc_plus4;
    logic                w_deliver;
    logic [INSTR_W-1:0]  w_deliver_instr;

    // Execute is not frozen by o_stall_i, so a redirect is visible for one
    // cycle only; a younger redirect overrides any pending one.
    assign w_redir     = i_pc_src_exec & ~i_stall_d;
    assign w_redir_any = w_redir | r_pend_v;
    assign w_target    = w_redir ? i_pc_target_exec : r_pend_pc;
    assign w_pc_plus4  = r_pc + c_four;

    assign o_imem_req  = (r_state == ST_FETCH) & ~i_rst;
    assign o_imem_addr = r_pc;
    assign o_stall_i   = o_imem_req & ~i_imem_ack;

    always_comb begin
        w_deliver       = 1'b0;
        w_deliver_instr = i_imem_data;
        if (r_state == ST_FETCH) begin
            w_deliver = i_imem_ack & ~w_redir_any & ~i_stall_fetch;
        end else begin
            w_deliver       = ~w_redir & ~i_stall_fetch;
            w_deliver_instr = r_buf_instr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_FETCH;
            r_pc           <= RESET_PC;
            r_pend_v       <= 1'b0;
            r_pend_pc      <= '0;
            r_buf_instr    <= c_nop;
            o_instr_dec    <= c_nop;
            o_pc_dec       <= '0;
            o_pc_plus4_dec <= '0;
            o_valid_dec    <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (i_imem_ack) begin
                        if (w_redir_any) begin
                            r_pc     <= w_target;
                            r_pend_v <= 1'b0;
                        end else if (i_stall_fetch) begin
                            r_buf_instr <= i_imem_data;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end else if (w_redir) begin
                        // Outstanding request is never aborted; remember the target.
                        r_pend_v  <= 1'b1;
                        r_pend_pc <= i_pc_target_exec;
                    end
                end
                ST_HOLD: begin
                    if (w_redir) begin
                        r_pc    <= i_pc_target_exec;
                        r_state <= ST_FETCH;
                    end else if (!i_stall_fetch) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase

            if (i_flush_dec || w_redir_any) begin
                o_instr_dec    <= c_nop;
                o_pc_dec       <= '0;
                o_pc_plus4_dec <= '0;
                o_valid_dec    <= 1'b0;
            end else if (i_stall_dec) begin
                o_instr_dec    <= o_instr_dec;
                o_pc_dec       <= o_pc_dec;
                o_pc_plus4_dec <= o_pc_plus4_dec;
                o_valid_dec    <= o_valid_dec;
            end else if (w_deliver) begin
                o_instr_dec    <= w_deliver_instr;
                o_pc_dec       <= r_pc;
                o_pc_plus4_dec <= w_pc_plus4;
                o_valid_dec    <= 1'b1;
            end else begin
                o_instr_dec    <= c_nop;
                o_pc_dec       <= '0;
                o_pc_plus4_dec <= '0;
                o_valid_dec    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage; one expected decode entry
//               is queued per driven cycle and checked after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_fetch = 1'b0;
    logic        stall_dec = 1'b0;
    logic        flush_dec = 1'b0;
    logic        pc_src = 1'b0;
    logic [63:0] pc_target = '0;
    logic        stall_d = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        stall_i;
    logic [31:0] instr_dec;
    logic [63:0] pc_dec;
    logic [63:0] pc_plus4_dec;
    logic        valid_dec;

    fetch_stage #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall_fetch    (stall_fetch),
        .i_stall_dec      (stall_dec),
        .i_flush_dec      (flush_dec),
        .i_pc_src_exec    (pc_src),
        .i_pc_target_exec (pc_target),
        .i_stall_d        (stall_d),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_data      (imem_data),
        .o_stall_i        (stall_i),
        .o_instr_dec      (instr_dec),
        .o_pc_dec         (pc_dec),
        .o_pc_plus4_dec   (pc_plus4_dec),
        .o_valid_dec      (valid_dec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory-side outputs, sampled shortly after the inputs settle.
    task automatic comb(input string tag, input logic req, input logic [63:0] addr,
                        input logic stl);
        #1;
        chk({tag, ".req"},     64'(imem_req), 64'(req));
        chk({tag, ".addr"},    imem_addr,     addr);
        chk({tag, ".stall_i"}, 64'(stall_i),  64'(stl));
    endtask

    // Queue the expected decode contents, clock once, then compare.
    task automatic step(input string tag, input logic v, input logic [63:0] pc,
                        input logic [31:0] ins);
        exp_t e;
        e.v     = v;
        e.pc    = v ? pc : 64'h0;
        e.instr = v ? ins : c_nop;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"}, 64'(valid_dec), 64'(e.v));
        chk({tag, ".pc"},    pc_dec,         e.pc);
        chk({tag, ".pc4"},   pc_plus4_dec,   e.v ? e.pc + 64'd4 : 64'h0);
        chk({tag, ".instr"}, 64'(instr_dec), 64'(e.instr));
    endtask

    initial begin
        // Reset, including an ack that must be ignored
        comb("rst0", 1'b0, 64'h0, 1'b0);
        step("rst0", 1'b0, 64'h0, 32'h0);
        imem_ack = 1'b1; imem_data = 32'hBAD0_0000;
        comb("rst1", 1'b0, 64'h0, 1'b0);
        step("rst1", 1'b0, 64'h0, 32'h0);
        rst = 1'b0;

        // Zero-wait memory: 0, 4, 8, C
        for (int k = 0; k < 4; k++) begin
            imem_ack = 1'b1; imem_data = 32'(k * 4);
            comb("zw", 1'b1, 64'(k * 4), 1'b0);
            step("zw", 1'b1, 64'(k * 4), 32'(k * 4));
        end

        // Load-use stall at the ack of 0x10
        imem_data = 32'h10; stall_fetch = 1'b1; stall_dec = 1'b1;
        comb("lu_ack", 1'b1, 64'h10, 1'b0);
        step("lu_ack", 1'b1, 64'hC, 32'hC);
        chk("lu_hold_state", 64'(dut.r_state), 64'(1));
        imem_ack = 1'b0;
        comb("lu_hold", 1'b0, 64'h10, 1'b0);
        step("lu_hold", 1'b1, 64'hC, 32'hC);
        stall_fetch = 1'b0; stall_dec = 1'b0;
        comb("lu_rel", 1'b0, 64'h10, 1'b0);
        step("lu_rel", 1'b1, 64'h10, 32'h10);

        // Three-cycle memory latency at 0x14
        for (int k = 0; k < 3; k++) begin
            comb("lat_wait", 1'b1, 64'h14, 1'b1);
            step("lat_wait", 1'b0, 64'h0, 32'h0);
        end
        imem_ack = 1'b1; imem_data = 32'h14;
        comb("lat_ack", 1'b1, 64'h14, 1'b0);
        step("lat_ack", 1'b1, 64'h14, 32'h14);

        // Redirect to 0x200 with no fetch left outstanding
        imem_data = 32'h18; pc_src = 1'b1; pc_target = 64'h200;
        comb("rd200", 1'b1, 64'h18, 1'b0);
        step("rd200", 1'b0, 64'h0, 32'h0);
        pc_src = 1'b0; imem_data = 32'h200;
        comb("rd200_new", 1'b1, 64'h200, 1'b0);
        step("rd200_new", 1'b1, 64'h200, 32'h200);

        // Redirect to 0x300 two cycles before a slow ack at 0x204
        imem_ack = 1'b0; pc_src = 1'b1; pc_target = 64'h300;
        comb("rd300_a", 1'b1, 64'h204, 1'b1);
        step("rd300_a", 1'b0, 64'h0, 32'h0);
        chk("rd300_pend_v", 64'(dut.r_pend_v), 64'(1));
        pc_src = 1'b0; pc_target = 64'h0;
        comb("rd300_b", 1'b1, 64'h204, 1'b1);
        step("rd300_b", 1'b0, 64'h0, 32'h0);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        comb("rd300_ack", 1'b1, 64'h204, 1'b0);
        step("rd300_ack", 1'b0, 64'h0, 32'h0);
        imem_data = 32'h300;
        comb("rd300_new", 1'b1, 64'h300, 1'b0);
        step("rd300_new", 1'b1, 64'h300, 32'h300);

        // Redirect while the data side is stalled is ignored, then taken
        imem_ack = 1'b0; pc_src = 1'b1; pc_target = 64'h400; stall_d = 1'b1;
        comb("sd_block", 1'b1, 64'h304, 1'b1);
        step("sd_block", 1'b0, 64'h0, 32'h0);
        chk("sd_pend_v", 64'(dut.r_pend_v), 64'(0));
        stall_d = 1'b0; imem_ack = 1'b1; imem_data = 32'h304;
        comb("sd_take", 1'b1, 64'h304, 1'b0);
        step("sd_take", 1'b0, 64'h0, 32'h0);
        pc_src = 1'b0;

        // Flush beats decode stall; PC still advances
        imem_data = 32'h400; flush_dec = 1'b1; stall_dec = 1'b1;
        comb("flush", 1'b1, 64'h400, 1'b0);
        step("flush", 1'b0, 64'h0, 32'h0);
        flush_dec = 1'b0; stall_dec = 1'b0;

        // PC wrap at the top of the address space
        imem_data = 32'h404; pc_src = 1'b1; pc_target = 64'hFFFF_FFFF_FFFF_FFFC;
        comb("wrap_rd", 1'b1, 64'h404, 1'b0);
        step("wrap_rd", 1'b0, 64'h0, 32'h0);
        pc_src = 1'b0; imem_data = 32'h1357_2468;
        comb("wrap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        step("wrap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1357_2468);
        imem_data = 32'h0;
        comb("wrap_zero", 1'b1, 64'h0, 1'b0);
        step("wrap_zero", 1'b1, 64'h0, 32'h0);
        imem_data = 32'h4;
        comb("wrap_four", 1'b1, 64'h4, 1'b0);
        step("wrap_four", 1'b1, 64'h4, 32'h4);

        // Reset with a fetch outstanding; the ack during reset is ignored
        imem_ack = 1'b0;
        comb("mrst_wait", 1'b1, 64'h8, 1'b1);
        step("mrst_wait", 1'b0, 64'h0, 32'h0);
        rst = 1'b1; imem_ack = 1'b1; imem_data = 32'h8;
        comb("mrst_ack", 1'b0, 64'h8, 1'b0);
        step("mrst_ack", 1'b0, 64'h0, 32'h0);
        comb("mrst_in", 1'b0, 64'h0, 1'b0);
        rst = 1'b0; imem_ack = 1'b0;
        comb("mrst_out", 1'b1, 64'h0, 1'b1);
        step("mrst_out", 1'b0, 64'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
